// File: rtl/deskew_matrix_collector.sv
// Receive side of the systolic array's skewed-wavefront interface: collects
// 2*SIZE-1 diagonal beats and rebuilds the SIZE x SIZE result matrix.
module deskew_matrix_collector #(
    parameter int WIDTH = 4,
    parameter int SIZE  = 3
) (
    input  logic                                 clock,
    input  logic                                 nreset,
    input  logic                                 flush,
    input  logic                                 in_valid,
    output logic                                 in_ready,
    input  logic [SIZE*WIDTH-1:0]                in_vec,
    output logic                                 out_valid,
    input  logic                                 out_ready,
    output logic [SIZE-1:0][SIZE-1:0][WIDTH-1:0] Mout,
    output logic [$clog2(2*SIZE)-1:0]            beat_cnt,
    output logic                                 pad_err
);
    localparam int CW        = $clog2(2*SIZE);
    localparam int LAST_BEAT = 2*SIZE-2;

    localparam logic [0:0] COLLECT = 1'b0;
    localparam logic [0:0] HOLD    = 1'b1;

    logic [0:0]                           state_r;
    logic [0:0]                           state_nx_s;
    logic [CW-1:0]                        beat_cnt_r;
    logic [CW-1:0]                        beat_cnt_nx_s;
    logic                                 in_ready_r;
    logic                                 out_valid_r;
    logic                                 pad_err_r;
    logic [SIZE-1:0][SIZE-1:0][WIDTH-1:0] mout_r;
    logic                                 accept_s;
    logic                                 pad_hit_s;

    // Lane j of beat k is padding unless 0 <= k-j < SIZE; padding must be zero.
    function automatic logic pad_nonzero(input logic [SIZE*WIDTH-1:0] vec,
                                         input logic [CW-1:0] k);
        logic hit;
        hit = 1'b0;
        for (int j = 0; j < SIZE; j++) begin
            if ((int'(k) < j) || ((int'(k) - j) >= SIZE)) begin
                hit = hit | (|vec[j*WIDTH +: WIDTH]);
            end else begin
                hit = hit;
            end
        end
        return hit;
    endfunction

    assign accept_s  = in_valid & in_ready_r;
    assign pad_hit_s = accept_s & pad_nonzero(in_vec, beat_cnt_r);

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign beat_cnt  = beat_cnt_r;
    assign pad_err   = pad_err_r;
    assign Mout      = mout_r;

    // Next-state and beat counter; the last beat wraps the counter into HOLD.
    always_comb begin
        state_nx_s    = state_r;
        beat_cnt_nx_s = beat_cnt_r;
        case (state_r)
            COLLECT: begin
                if (accept_s) begin
                    if (beat_cnt_r == CW'(LAST_BEAT)) begin
                        state_nx_s    = HOLD;
                        beat_cnt_nx_s = {CW{1'b0}};
                    end else begin
                        beat_cnt_nx_s = beat_cnt_r + CW'(1);
                    end
                end else begin
                    state_nx_s = COLLECT;
                end
            end
            HOLD: begin
                if (out_ready) begin
                    state_nx_s = COLLECT;
                end else begin
                    state_nx_s = HOLD;
                end
            end
            default: begin
                state_nx_s    = COLLECT;
                beat_cnt_nx_s = {CW{1'b0}};
            end
        endcase
    end

    // Control registers; handshake outputs are decoded from the next state.
    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            state_r     <= COLLECT;
            beat_cnt_r  <= {CW{1'b0}};
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            pad_err_r   <= 1'b0;
        end else if (flush) begin
            state_r     <= COLLECT;
            beat_cnt_r  <= {CW{1'b0}};
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            pad_err_r   <= 1'b0;
        end else begin
            state_r     <= state_nx_s;
            beat_cnt_r  <= beat_cnt_nx_s;
            in_ready_r  <= (state_nx_s == COLLECT);
            out_valid_r <= (state_nx_s == HOLD);
            pad_err_r   <= pad_err_r | pad_hit_s;
        end
    end

    // Matrix storage: element [r][c] arrives on lane c of beat r+c; flush keeps contents.
    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            mout_r <= {(SIZE*SIZE*WIDTH){1'b0}};
        end else if (!flush && accept_s) begin
            for (int r = 0; r < SIZE; r++) begin
                for (int c = 0; c < SIZE; c++) begin
                    if (int'(beat_cnt_r) == (r + c)) begin
                        mout_r[r][c] <= in_vec[c*WIDTH +: WIDTH];
                    end
                end
            end
        end
    end

endmodule
